// File: rtl/loop_cond_sequencer_pkg.sv
// Shared definitions for the loop condition sequencer.
// The state encoding is exported so bench assertions can decode the debug state.
package loop_cond_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        EXIT = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/loop_cond_sequencer.sv
// Dataless loop controller: takes a trip count N, then emits N "iterate" condition
// tokens, one "exit" token (index N) and finally a dataless done token.
module loop_cond_sequencer
    import loop_cond_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] start_data,
    input  logic             start_valid,
    output logic             start_ready,
    output logic             condition,
    output logic [WIDTH-1:0] condition_index,
    output logic             condition_valid,
    input  logic             condition_ready,
    output logic             done_valid,
    input  logic             done_ready,
    output state_t           dbg_state
);

    // Handshake: a transfer happens on a cycle where valid & ready are both high.
    // Every valid is a pure decode of r_state, so it never depends on a ready and
    // it holds (with r_idx stable) until its transfer.

    localparam logic [WIDTH-1:0] W_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] r_idx;
    logic [WIDTH-1:0] w_idx_nxt;
    logic             w_cond_xfer;
    logic             w_last_iter;

    assign start_ready     = (r_state == IDLE);
    assign condition_valid = (r_state == ITER) || (r_state == EXIT);
    assign done_valid      = (r_state == DONE);
    assign condition       = (r_state == ITER);
    assign condition_index = r_idx;
    assign dbg_state       = r_state;

    assign w_cond_xfer = condition_valid && condition_ready;
    // r_count is never zero in ITER, so count-1 cannot underflow and N=2^WIDTH-1 never wraps r_idx.
    assign w_last_iter = (r_idx == (r_count - W_ONE));

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_idx_nxt   = r_idx;
        case (r_state)
            IDLE: begin
                if (start_valid) begin
                    w_count_nxt = start_data;
                    w_idx_nxt   = '0;
                    w_state_nxt = (start_data != '0) ? ITER : EXIT;
                end
            end
            ITER: begin
                if (w_cond_xfer) begin
                    w_idx_nxt = r_idx + W_ONE;
                    if (w_last_iter) begin
                        w_state_nxt = EXIT;
                    end
                end
            end
            EXIT: begin
                if (w_cond_xfer) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (done_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_count <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

endmodule
